// File: rtl/fifo_pkg.sv
// Shared pointer helpers for both sides of the asynchronous FIFO.
// Functions operate on a 32-bit container; callers zero-extend and truncate to their pointer width.
`default_nettype none

package fifo_pkg;

  localparam int PTR_MAX_W = 32;

  typedef logic [PTR_MAX_W-1:0] ptr_word_t;

  // Pointers carry one extra bit beyond the address so full and empty are distinguishable.
  function automatic int ptr_width(input int addr_w);
    return addr_w + 1;
  endfunction

  function automatic ptr_word_t bin2gray(input ptr_word_t bin);
    return bin ^ (bin >> 1);
  endfunction

  function automatic ptr_word_t gray2bin(input ptr_word_t gray);
    ptr_word_t bin;
    bin[PTR_MAX_W-1] = gray[PTR_MAX_W-1];
    for (int i = PTR_MAX_W - 2; i >= 0; i--) begin
      bin[i] = bin[i+1] ^ gray[i];
    end
    return bin;
  endfunction

endpackage

`default_nettype wire

// File: rtl/fifo_sync2.sv
// Generic two-flop synchroniser with asynchronous active-low reset to zero.
`default_nettype none

module fifo_sync2 #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

`default_nettype wire

// File: rtl/fifo_rptr_empty.sv
// Read-side controller of the asynchronous FIFO: read pointers, empty/level status
// and a registered valid/ready output stage fed from the memory's combinational read port.
`default_nettype none

module fifo_rptr_empty
  import fifo_pkg::*;
#(
  parameter int DATA_W       = 8,
  parameter int ADDR_W       = 4,
  parameter int ALMOST_EMPTY = 2
) (
  input  logic              i_rclk,
  input  logic              i_rrst_n,
  input  logic [ADDR_W:0]   i_wptrGray,
  input  logic [DATA_W-1:0] i_rdata,
  output logic [ADDR_W-1:0] o_raddr,
  output logic [ADDR_W:0]   o_rptrGray,
  output logic              o_rempty,
  output logic              o_ralmostEmpty,
  output logic [ADDR_W:0]   o_rlevel,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [DATA_W-1:0] o_data
);

  localparam int               PTR_W  = ptr_width(ADDR_W);
  localparam logic [PTR_W-1:0] AE_THR = PTR_W'(ALMOST_EMPTY);

  logic [PTR_W-1:0] wq2_wptrGray;
  logic [PTR_W-1:0] rbin;
  logic [PTR_W-1:0] rgray;
  logic [PTR_W-1:0] rbin_next;
  logic [PTR_W-1:0] rgray_next;
  logic [PTR_W-1:0] wbin;
  logic [PTR_W-1:0] level_next;
  logic             pop;

  fifo_sync2 #(
    .WIDTH (PTR_W)
  ) u_wptr_sync (
    .clk   (i_rclk),
    .rst_n (i_rrst_n),
    .d     (i_wptrGray),
    .q     (wq2_wptrGray)
  );

  // Refill the output stage whenever it is empty or being drained this cycle.
  assign pop        = !o_rempty && (!o_valid || i_ready);
  assign rbin_next  = rbin + {{(PTR_W-1){1'b0}}, pop};
  assign rgray_next = PTR_W'(bin2gray(PTR_MAX_W'(rbin_next)));
  assign wbin       = PTR_W'(gray2bin(PTR_MAX_W'(wq2_wptrGray)));
  assign level_next = wbin - rbin_next;

  assign o_raddr    = rbin[ADDR_W-1:0];
  assign o_rptrGray = rgray;

  always_ff @(posedge i_rclk or negedge i_rrst_n) begin
    if (!i_rrst_n) begin
      rbin           <= '0;
      rgray          <= '0;
      o_rempty       <= 1'b1;
      o_ralmostEmpty <= 1'b1;
      o_rlevel       <= '0;
      o_valid        <= 1'b0;
      o_data         <= '0;
    end else begin
      rbin           <= rbin_next;
      rgray          <= rgray_next;
      o_rempty       <= (rgray_next == wq2_wptrGray);
      o_rlevel       <= level_next;
      o_ralmostEmpty <= (level_next <= AE_THR);
      if (pop) begin
        o_data  <= i_rdata;
        o_valid <= 1'b1;
      end else if (i_ready) begin
        o_valid <= 1'b0;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_fifo_rptr_empty.sv
// Directed bench for fifo_rptr_empty: writer model plus scoreboard queue checked by a negedge monitor.
`default_nettype none

module tb_fifo_rptr_empty;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] wptr_gray;
  logic [7:0] rdata;
  logic [3:0] raddr;
  logic [4:0] rptr_gray;
  logic       rempty;
  logic       ralmost;
  logic [4:0] rlevel;
  logic       valid;
  logic       ready;
  logic [7:0] data;

  logic [7:0] mem [16];
  logic [7:0] exp_q [$];
  logic [4:0] wbin;
  logic [7:0] seq;
  int         total = 0;
  int         bad = 0;
  int         wtotal = 0;
  int         accepted = 0;
  bit         lvl_chk = 1'b0;

  always #5 clk = ~clk;

  assign rdata = mem[raddr];

  fifo_rptr_empty #(
    .DATA_W       (8),
    .ADDR_W       (4),
    .ALMOST_EMPTY (2)
  ) dut (
    .i_rclk         (clk),
    .i_rrst_n       (rst_n),
    .i_wptrGray     (wptr_gray),
    .i_rdata        (rdata),
    .o_raddr        (raddr),
    .o_rptrGray     (rptr_gray),
    .o_rempty       (rempty),
    .o_ralmostEmpty (ralmost),
    .o_rlevel       (rlevel),
    .o_valid        (valid),
    .i_ready        (ready),
    .o_data         (data)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic write_word();
    mem[wbin[3:0]] = seq;
    exp_q.push_back(seq);
    seq       = seq + 8'd37;
    wbin      = wbin + 5'd1;
    wptr_gray = wbin ^ (wbin >> 1);
    wtotal++;
  endtask

  // Scoreboard monitor: a word is consumed at the edge following a negedge where valid && ready.
  always @(negedge clk) begin
    if (rst_n) begin
      if (lvl_chk) begin
        total++;
        if (int'(rlevel) > wtotal - accepted - int'(valid)) begin
          bad++;
          $display("FAIL level_bound: got %0d want <= %0d", rlevel, wtotal - accepted - int'(valid));
        end
      end
      if (valid && ready) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL stream_extra: got %0h want no word", data);
        end else begin
          logic [7:0] d;
          d = exp_q.pop_front();
          if (data !== d) begin
            bad++;
            $display("FAIL stream_data: got %0h want %0h", data, d);
          end
        end
        accepted++;
      end
    end
  end

  initial begin
    logic [7:0] bp_word;
    int         written;

    rst_n     = 1'b0;
    ready     = 1'b0;
    wptr_gray = '0;
    wbin      = '0;
    seq       = 8'h11;
    for (int i = 0; i < 16; i++) mem[i] = 8'hEE;

    // Reset state
    tick(2);
    check("rst_empty", 32'(rempty), 1);
    check("rst_almost", 32'(ralmost), 1);
    check("rst_level", 32'(rlevel), 0);
    check("rst_valid", 32'(valid), 0);
    check("rst_raddr", 32'(raddr), 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick(2);

    // Single word: visible after 3 edges, popped on the 4th
    write_word();
    tick(2);
    check("sw_empty_e2", 32'(rempty), 1);
    tick(1);
    check("sw_empty_e3", 32'(rempty), 0);
    check("sw_level_e3", 32'(rlevel), 1);
    check("sw_almost_e3", 32'(ralmost), 1);
    check("sw_valid_e3", 32'(valid), 0);
    tick(1);
    check("sw_valid_e4", 32'(valid), 1);
    check("sw_empty_e4", 32'(rempty), 1);
    check("sw_raddr_e4", 32'(raddr), 1);
    check("sw_level_e4", 32'(rlevel), 0);
    ready = 1'b1;
    tick(1);
    check("sw_valid_done", 32'(valid), 0);
    ready = 1'b0;
    tick(2);

    // Back-pressure: four words, one pop, held data, then burst
    bp_word = seq;
    repeat (4) write_word();
    tick(4);
    check("bp_valid", 32'(valid), 1);
    check("bp_level", 32'(rlevel), 3);
    check("bp_almost", 32'(ralmost), 0);
    for (int i = 0; i < 10; i++) begin
      tick(1);
      check("bp_hold_data", 32'(data), 32'(bp_word));
      check("bp_hold_level", 32'(rlevel), 3);
    end
    ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick(1);
      check("bp_burst_valid", 32'(valid), 1);
    end
    check("bp_burst_empty", 32'(rempty), 1);
    tick(1);
    check("bp_burst_end", 32'(valid), 0);
    ready = 1'b0;
    tick(2);

    // Full FIFO and almost-empty threshold while draining
    repeat (16) write_word();
    tick(3);
    check("full_level", 32'(rlevel), 16);
    check("full_almost", 32'(ralmost), 0);
    check("full_empty", 32'(rempty), 0);
    tick(1);
    check("full_level_pop", 32'(rlevel), 15);
    ready = 1'b1;
    for (int k = 1; k <= 15; k++) begin
      tick(1);
      check("drain_level", 32'(rlevel), 32'(15 - k));
      check("drain_almost", 32'(ralmost), (15 - k <= 2) ? 32'd1 : 32'd0);
    end
    check("drain_empty", 32'(rempty), 1);
    tick(1);
    check("drain_valid_end", 32'(valid), 0);

    // Wrap: 40 words streamed through, pointer crosses 31 -> 0
    written = 0;
    for (int c = 0; c < 400; c++) begin
      if (written < 40 && wtotal - accepted < 12) begin
        write_word();
        written++;
      end
      tick(1);
      if (written == 40 && exp_q.size() == 0 && !valid) break;
    end
    tick(4);
    check("wrap_queue_left", 32'(exp_q.size()), 0);
    check("wrap_empty", 32'(rempty), 1);
    check("wrap_valid", 32'(valid), 0);
    check("wrap_raddr", 32'(raddr), 32'(wbin[3:0]));
    check("wrap_rptr_gray", 32'(rptr_gray), 32'(wptr_gray));

    // Synchroniser: one Gray step at a time with random back-pressure
    lvl_chk = 1'b1;
    for (int c = 0; c < 200; c++) begin
      if ($urandom_range(0, 1) == 1 && wtotal - accepted < 16) write_word();
      ready = ($urandom_range(0, 2) != 0);
      tick(1);
    end
    ready = 1'b1;
    for (int c = 0; c < 100 && (exp_q.size() != 0 || valid); c++) tick(1);
    lvl_chk = 1'b0;
    check("rand_queue_left", 32'(exp_q.size()), 0);
    check("rand_empty", 32'(rempty), 1);
    check("rand_level", 32'(rlevel), 0);

    // Reset mid-stream: held word discarded immediately
    ready = 1'b0;
    repeat (3) write_word();
    tick(4);
    check("mid_valid_before", 32'(valid), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_empty", 32'(rempty), 1);
    check("mid_rst_almost", 32'(ralmost), 1);
    check("mid_rst_level", 32'(rlevel), 0);
    check("mid_rst_valid", 32'(valid), 0);
    check("mid_rst_raddr", 32'(raddr), 0);
    exp_q.delete();
    wbin      = '0;
    wptr_gray = '0;
    wtotal    = 0;
    accepted  = 0;
    @(negedge clk);
    rst_n = 1'b1;
    tick(5);
    check("post_rst_empty", 32'(rempty), 1);
    check("post_rst_valid", 32'(valid), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
